// File: rtl/seu_npu_ccr_bank_if.sv
// rtl/seu_npu_ccr_bank_if.sv - register access bus between the biu and the npu ccr bank
interface seu_npu_ccr_bank_if #(
  parameter int CCR_AW = 32,
  parameter int DW     = 64
);
  logic [CCR_AW-1:0] reg_addr;
  logic [DW-1:0]     reg_wdata;
  logic [DW/8-1:0]   reg_sel;
  logic              reg_wen;
  logic              reg_ren;
  logic [DW-1:0]     reg_rdata;
  logic              reg_ack;
  logic              reg_err;

  modport master (output reg_addr, reg_wdata, reg_sel, reg_wen, reg_ren,
                  input  reg_rdata, reg_ack, reg_err);
  modport slave  (input  reg_addr, reg_wdata, reg_sel, reg_wen, reg_ren,
                  output reg_rdata, reg_ack, reg_err);
endinterface

// File: rtl/seu_npu_ccr_bank.sv
// rtl/seu_npu_ccr_bank.sv - npu control/config register bank with start snapshot and W1C interrupts
module seu_npu_ccr_bank #(
  parameter int                CCR_AW    = 32,
  parameter int                OS_AW     = 16,
  parameter logic [CCR_AW-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int                DW        = 64,
  parameter int                CFG_NUM   = 8,
  parameter int                IRQ_NUM   = 4
) (
  input  logic                  clk_trans,
  input  logic                  rst_n,
  seu_npu_ccr_bank_if.slave     bus,
  input  logic                  npu_busy_sync_i,
  input  logic [IRQ_NUM-1:0]    irq_src_i,
  output logic                  npu_en_processing_o,
  output logic                  npu_start_o,
  output logic [CFG_NUM*DW-1:0] cfg_shadow_o,
  output logic                  irq_o
);
  localparam int WW  = OS_AW - 3;
  localparam int CIW = (CFG_NUM > 1) ? $clog2(CFG_NUM) : 1;
  localparam int NB  = DW / 8;

  logic [WW-1:0]  word, cfg_rel;
  logic [CIW-1:0] cfg_idx;
  logic           bank_hit, aligned, mapped;
  logic           is_en, is_ctrl, is_stat, is_istat, is_imask, is_cfg;
  logic           access, start_req, err_c, wr_ok, rd_ok;
  logic [DW-1:0]  wmask;

  logic                  en_q, en_d;
  logic [IRQ_NUM-1:0]    istat_q, istat_d, imask_q, imask_d, w1c;
  logic [DW-1:0]         cfg_q [CFG_NUM];
  logic [DW-1:0]         cfg_d [CFG_NUM];
  logic [CFG_NUM*DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  ack_q, err_q, start_q, irq_q;

  assign word     = bus.reg_addr[OS_AW-1:3];
  assign bank_hit = bus.reg_addr[CCR_AW-1:OS_AW] == BASE_ADDR[CCR_AW-1:OS_AW];
  assign aligned  = bus.reg_addr[2:0] == 3'b000;
  assign is_en    = word == WW'(0);
  assign is_ctrl  = word == WW'(1);
  assign is_stat  = word == WW'(2);
  assign is_istat = word == WW'(3);
  assign is_imask = word == WW'(4);
  // CFG words start at byte offset 0x400, i.e. word 128
  assign cfg_rel  = word - WW'(128);
  assign cfg_idx  = cfg_rel[CIW-1:0];
  assign is_cfg   = (word >= WW'(128)) && (32'(cfg_rel) < CFG_NUM);
  assign mapped   = is_en | is_ctrl | is_stat | is_istat | is_imask | is_cfg;

  assign access    = bus.reg_wen | bus.reg_ren;
  assign start_req = bus.reg_wen & is_ctrl & bus.reg_sel[0] & bus.reg_wdata[0];
  assign err_c     = access & (~bank_hit | ~aligned | ~mapped
                               | (bus.reg_wen & bus.reg_ren)
                               | (bus.reg_wen & is_stat)
                               | (bus.reg_wen & is_cfg & npu_busy_sync_i)
                               | (start_req & (npu_busy_sync_i | ~en_q)));
  assign wr_ok     = bus.reg_wen & ~err_c;
  assign rd_ok     = bus.reg_ren & ~err_c;

  always_comb begin
    wmask = '0;
    for (int j = 0; j < NB; j++) wmask[8*j +: 8] = {8{bus.reg_sel[j]}};
  end

  always_comb begin
    en_d     = en_q;
    imask_d  = imask_q;
    cfg_d    = cfg_q;
    shadow_d = shadow_q;
    w1c      = '0;
    rdata_d  = '0;
    if (wr_ok) begin
      if (is_en && bus.reg_sel[0]) en_d = bus.reg_wdata[0];
      if (is_istat) w1c = bus.reg_wdata[IRQ_NUM-1:0] & wmask[IRQ_NUM-1:0];
      if (is_imask) imask_d = (imask_q & ~wmask[IRQ_NUM-1:0])
                            | (bus.reg_wdata[IRQ_NUM-1:0] & wmask[IRQ_NUM-1:0]);
      if (is_cfg) cfg_d[cfg_idx] = (cfg_q[cfg_idx] & ~wmask) | (bus.reg_wdata & wmask);
      if (start_req) begin
        for (int i = 0; i < CFG_NUM; i++) shadow_d[i*DW +: DW] = cfg_q[i];
      end
    end
    if (rd_ok) begin
      if (is_en)    rdata_d[0] = en_q;
      if (is_stat)  rdata_d[0] = npu_busy_sync_i;
      if (is_istat) rdata_d[IRQ_NUM-1:0] = istat_q;
      if (is_imask) rdata_d[IRQ_NUM-1:0] = imask_q;
      if (is_cfg)   rdata_d = cfg_q[cfg_idx];
    end
    // a fresh event outranks a same-cycle clear
    istat_d = (istat_q & ~w1c) | irq_src_i;
  end

  always_ff @(posedge clk_trans or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      istat_q  <= '0;
      imask_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < CFG_NUM; i++) cfg_q[i] <= '0;
    end else begin
      en_q     <= en_d;
      istat_q  <= istat_d;
      imask_q  <= imask_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      ack_q    <= access;
      err_q    <= err_c;
      start_q  <= wr_ok & start_req;
      irq_q    <= |(istat_q & imask_q);
      for (int i = 0; i < CFG_NUM; i++) cfg_q[i] <= cfg_d[i];
    end
  end

  assign bus.reg_rdata         = rdata_q;
  assign bus.reg_ack           = ack_q;
  assign bus.reg_err           = err_q;
  assign npu_en_processing_o   = en_q;
  assign npu_start_o           = start_q;
  assign cfg_shadow_o          = shadow_q;
  assign irq_o                 = irq_q;
endmodule

// File: tb/tb_seu_npu_ccr_bank.sv
// tb/tb_seu_npu_ccr_bank.sv - scoreboard bench for the npu ccr bank
module tb_seu_npu_ccr_bank;
  localparam int DW      = 64;
  localparam int CFG_NUM = 8;
  localparam int IRQ_NUM = 4;
  localparam int SW      = CFG_NUM * DW;
  localparam logic [31:0] B = 32'h4000_0000;

  logic clk_trans = 1'b0;
  logic rst_n     = 1'b0;
  always #5 clk_trans = ~clk_trans;

  seu_npu_ccr_bank_if #(.CCR_AW(32), .DW(DW)) bus ();
  logic               npu_busy;
  logic [IRQ_NUM-1:0] irq_src;
  logic               en_o, start_o, irq_o;
  logic [SW-1:0]      shadow_o;

  seu_npu_ccr_bank #(.CCR_AW(32), .OS_AW(16), .BASE_ADDR(32'h4000_0000),
                     .DW(DW), .CFG_NUM(CFG_NUM), .IRQ_NUM(IRQ_NUM)) dut (
    .clk_trans           (clk_trans),
    .rst_n               (rst_n),
    .bus                 (bus),
    .npu_busy_sync_i     (npu_busy),
    .irq_src_i           (irq_src),
    .npu_en_processing_o (en_o),
    .npu_start_o         (start_o),
    .cfg_shadow_o        (shadow_o),
    .irq_o               (irq_o)
  );

  typedef struct { int cyc; logic [DW-1:0] rdata; logic err; } resp_t;
  typedef struct { int cyc; logic start; logic irq; logic en; logic [SW-1:0] sh; } side_t;
  resp_t resp_q[$];
  side_t side_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;
  always @(posedge clk_trans) cyc <= cyc + 1;

  logic               m_en;
  logic [IRQ_NUM-1:0] m_stat, m_mask;
  logic [DW-1:0]      m_cfg [CFG_NUM];
  logic [DW-1:0]      m_sh  [CFG_NUM];

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] pack_sh();
    logic [SW-1:0] v;
    for (int i = 0; i < CFG_NUM; i++) v[i*DW +: DW] = m_sh[i];
    return v;
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_stat = '0; m_mask = '0;
    for (int i = 0; i < CFG_NUM; i++) begin m_cfg[i] = '0; m_sh[i] = '0; end
  endtask

  // Drives one cycle and records what the bank must show one cycle later.
  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [DW-1:0] d,
                      input logic [7:0] s, input logic [IRQ_NUM-1:0] src, input logic busy);
    resp_t rp; side_t sd;
    int off, k;
    logic err, st;
    logic [DW-1:0] rd, bm;
    logic [IRQ_NUM-1:0] clr;
    bus.reg_wen = w; bus.reg_ren = r; bus.reg_addr = a; bus.reg_wdata = d; bus.reg_sel = s;
    irq_src = src; npu_busy = busy;
    for (int j = 0; j < 8; j++) bm[8*j +: 8] = s[j] ? 8'hFF : 8'h00;
    off = int'(a[15:0]);
    err = (a[31:16] != 16'h4000) || (off % 8 != 0) || (w && r);
    rd = '0; st = 1'b0; clr = '0;
    sd.irq = |(m_stat & m_mask);
    if (!err) begin
      if (off == 'h000) begin
        if (w) begin if (s[0]) m_en = d[0]; end else rd = {63'b0, m_en};
      end else if (off == 'h008) begin
        if (w && s[0] && d[0]) begin if (busy || !m_en) err = 1'b1; else st = 1'b1; end
      end else if (off == 'h010) begin
        if (w) err = 1'b1; else rd = {63'b0, busy};
      end else if (off == 'h018) begin
        if (w) clr = d[IRQ_NUM-1:0] & bm[IRQ_NUM-1:0]; else rd = {60'b0, m_stat};
      end else if (off == 'h020) begin
        if (w) m_mask = (m_mask & ~bm[IRQ_NUM-1:0]) | (d[IRQ_NUM-1:0] & bm[IRQ_NUM-1:0]);
        else rd = {60'b0, m_mask};
      end else if (off >= 'h400 && (off - 'h400) / 8 < CFG_NUM) begin
        k = (off - 'h400) / 8;
        if (w) begin
          if (busy) err = 1'b1; else m_cfg[k] = (m_cfg[k] & ~bm) | (d & bm);
        end else rd = m_cfg[k];
      end else err = 1'b1;
    end
    if (err) rd = '0;
    if (st) for (int i = 0; i < CFG_NUM; i++) m_sh[i] = m_cfg[i];
    m_stat = (m_stat & ~clr) | src;
    if (w || r) begin
      rp.cyc = cyc + 1; rp.rdata = rd; rp.err = err;
      resp_q.push_back(rp);
    end
    sd.cyc = cyc + 1; sd.start = st; sd.en = m_en; sd.sh = pack_sh();
    side_q.push_back(sd);
    @(posedge clk_trans); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, B, '0, 8'h00, '0, 1'b0);
  endtask

  resp_t mr; side_t ms; logic exp_ack;
  always @(negedge clk_trans) begin
    if (mon_en) begin
      exp_ack = (resp_q.size() > 0) && (resp_q[0].cyc == cyc);
      chk("ack", {511'b0, bus.reg_ack}, {511'b0, exp_ack});
      if (exp_ack) begin
        mr = resp_q.pop_front();
        if (bus.reg_ack) begin
          chk("rdata", {448'b0, bus.reg_rdata}, {448'b0, mr.rdata});
          chk("err", {511'b0, bus.reg_err}, {511'b0, mr.err});
        end
      end
      if ((side_q.size() > 0) && (side_q[0].cyc == cyc)) begin
        ms = side_q.pop_front();
        chk("npu_start", {511'b0, start_o}, {511'b0, ms.start});
        chk("irq", {511'b0, irq_o}, {511'b0, ms.irq});
        chk("en_processing", {511'b0, en_o}, {511'b0, ms.en});
        chk("cfg_shadow", shadow_o, ms.sh);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  logic [31:0] a;
  logic [DW-1:0] d;
  logic [7:0] s;
  logic w, r, bz;
  logic [IRQ_NUM-1:0] src;
  int kind;

  initial begin
    bus.reg_wen = 1'b0; bus.reg_ren = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_sel = '0;
    npu_busy = 1'b0; irq_src = '0;
    model_reset();
    repeat (2) @(posedge clk_trans);
    #1;
    chk("rst_ack", {511'b0, bus.reg_ack}, '0);
    chk("rst_err", {511'b0, bus.reg_err}, '0);
    chk("rst_rdata", {448'b0, bus.reg_rdata}, '0);
    chk("rst_start", {511'b0, start_o}, '0);
    chk("rst_irq", {511'b0, irq_o}, '0);
    chk("rst_en", {511'b0, en_o}, '0);
    chk("rst_shadow", shadow_o, '0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    step(1'b0, 1'b1, B + 32'h010, '0, 8'h00, '0, 1'b1);
    step(1'b1, 1'b0, B + 32'h410, 64'h1122_3344_5566_7788, 8'h0F, '0, 1'b0);
    step(1'b0, 1'b1, B + 32'h410, '0, 8'h00, '0, 1'b0);
    step(1'b1, 1'b0, B + 32'h000, 64'h1, 8'h01, '0, 1'b0);
    step(1'b1, 1'b0, B + 32'h400, 64'hDEAD_BEEF_0123_4567, 8'hFF, '0, 1'b0);
    step(1'b1, 1'b0, B + 32'h008, 64'h1, 8'h01, '0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, B + 32'h008, 64'h1, 8'h01, '0, 1'b1);
    step(1'b1, 1'b0, B + 32'h400, 64'h5555, 8'hFF, '0, 1'b1);
    step(1'b0, 1'b1, B + 32'h400, '0, 8'h00, '0, 1'b1);
    step(1'b0, 1'b1, B + 32'h408 + 32'(8 * CFG_NUM), '0, 8'h00, '0, 1'b0);
    step(1'b1, 1'b0, B + 32'h020, 64'h5, 8'hFF, '0, 1'b0);
    step(1'b0, 1'b0, B, '0, 8'h00, 4'b0001, 1'b0);
    idle(3);
    step(1'b1, 1'b0, B + 32'h018, 64'h1, 8'hFF, 4'b0001, 1'b0);
    step(1'b0, 1'b1, B + 32'h018, '0, 8'h00, '0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, B + 32'h018, 64'h1, 8'hFF, '0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, B + 32'h418, 64'hA5A5_0F0F_1234_9876, 8'hFF, '0, 1'b0);
    step(1'b0, 1'b1, B + 32'h418, '0, 8'h00, '0, 1'b0);
    step(1'b1, 1'b1, B + 32'h418, 64'hFFFF, 8'hFF, '0, 1'b0);
    step(1'b0, 1'b1, B + 32'h418, '0, 8'h00, '0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 11));
      case (kind)
        0:       a = B + 32'h000;
        1:       a = B + 32'h008;
        2:       a = B + 32'h010;
        3:       a = B + 32'h018;
        4:       a = B + 32'h020;
        8:       a = B + 32'h404;
        9:       a = 32'h5000_0400;
        10:      a = B + 32'h028;
        default: a = B + 32'h400 + 32'(8 * $urandom_range(0, CFG_NUM));
      endcase
      kind = int'($urandom_range(0, 9));
      w = (kind <= 3) || (kind == 8);
      r = ((kind >= 4) && (kind <= 7)) || (kind == 8);
      d = {$urandom, $urandom};
      s = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      src = ($urandom_range(0, 5) == 0) ? IRQ_NUM'($urandom) : '0;
      bz = ($urandom_range(0, 3) == 0);
      step(w, r, a, d, s, src, bz);
    end
    idle(3);
    chk("drain_resp", SW'(resp_q.size()), '0);

    mon_en = 1'b0;
    bus.reg_wen = 1'b1; bus.reg_ren = 1'b0; bus.reg_addr = B + 32'h408;
    bus.reg_wdata = 64'h0BAD_F00D_0BAD_F00D; bus.reg_sel = 8'hFF;
    #2 rst_n = 1'b0;
    @(negedge clk_trans);
    chk("midrst_ack", {511'b0, bus.reg_ack}, '0);
    @(posedge clk_trans); #1;
    bus.reg_wen = 1'b0;
    rst_n = 1'b1;
    resp_q.delete();
    side_q.delete();
    model_reset();
    mon_en = 1'b1;
    step(1'b0, 1'b1, B + 32'h408, '0, 8'h00, '0, 1'b0);
    step(1'b0, 1'b1, B + 32'h000, '0, 8'h00, '0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
